// File: rtl/ng_subseq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ng_subseq_gen
//  Brief    : Sub-sequence generator. Runs the 12-pulse instruction-cycle
//             timer, holds the sequence (SQ) and stage (ST) registers,
//             inserts at most one counter-increment cycle between instruction
//             cycles, and encodes the 8-bit SUBSEQ word
//             {SB_02, SB_01, SQ[3:0], STB_1, STB_0}.
//  Revision : 1.0 - initial release
// ============================================================================
module ng_subseq_gen (
    input  logic       CLK2,
    input  logic       NPURST,
    input  logic       RUN,
    input  logic       NEWSQ,
    input  logic [3:0] SQ_IN,
    input  logic       STG_ADV,
    input  logic [1:0] STG_NXT,
    input  logic       CNT_REQ,
    input  logic       CNT_DIR,
    output logic       CNT_ACK,
    output logic [7:0] SUBSEQ,
    output logic [3:0] TPULSE,
    output logic       EOC,
    output logic       SEQ_VALID
);

    // Cycle-type encodings held in the SB register
    localparam logic [1:0] c_SB_INSTR = 2'b00;
    localparam logic [1:0] c_SB_PLUS  = 2'b01;
    localparam logic [1:0] c_SB_MINUS = 2'b10;

    // Last time pulse of the cycle (T12)
    localparam logic [3:0] c_TP_LAST  = 4'd11;

    // Counter cycles present no sequence to the decoder
    localparam logic [5:0] c_NO_SEQ   = 6'b111111;

    // Legal-sequence masks, one bit per SQ value, selected by stage
    localparam logic [15:0] c_ST0_MASK = 16'hFE0F; // SQ 0-3, 11-17 (octal)
    localparam logic [15:0] c_ST1_MASK = 16'h0607; // SQ 0, 1, 2, 11, 12
    localparam logic [15:0] c_ST2_MASK = 16'h0C09; // SQ 0, 3, 12, 13
    localparam logic [15:0] c_ST3_MASK = 16'h0000; // no legal sequences

    logic [3:0]  r_tp;
    logic [3:0]  r_sq;
    logic [1:0]  r_st;
    logic [1:0]  r_sb;
    logic        r_cnt_ack;

    logic        w_eoc;
    logic        w_counter_cycle;
    logic [15:0] w_stage_mask;

    assign w_eoc           = RUN & (r_tp == c_TP_LAST);
    assign w_counter_cycle = (r_sb != c_SB_INSTR);

    // Timer, sequence/stage update and counter-cycle arbitration
    always_ff @(posedge CLK2 or negedge NPURST) begin
        if (!NPURST) begin
            r_tp      <= 4'd0;
            r_sq      <= 4'd0;
            r_st      <= 2'd0;
            r_sb      <= c_SB_INSTR;
            r_cnt_ack <= 1'b0;
        end else begin
            // The grant pulse lasts one clock even while the timer is frozen
            r_cnt_ack <= 1'b0;
            if (RUN) begin
                r_tp <= (r_tp == c_TP_LAST) ? 4'd0 : r_tp + 4'd1;
                if (w_eoc) begin
                    // Sequence update applies even when a counter cycle is
                    // inserted; it surfaces once the counter cycle is over
                    if (NEWSQ) begin
                        r_sq <= SQ_IN;
                        r_st <= 2'd0;
                    end else if (STG_ADV) begin
                        r_st <= STG_NXT;
                    end
                    // Only an instruction cycle may be followed by a counter
                    // cycle, so instructions can never starve
                    if (!w_counter_cycle && CNT_REQ) begin
                        r_sb      <= CNT_DIR ? c_SB_MINUS : c_SB_PLUS;
                        r_cnt_ack <= 1'b1;
                    end else begin
                        r_sb      <= c_SB_INSTR;
                    end
                end
            end
        end
    end

    // Select the legal-SQ mask for the stored stage
    always_comb begin
        w_stage_mask = c_ST3_MASK;
        case (r_st)
            2'd0:    w_stage_mask = c_ST0_MASK;
            2'd1:    w_stage_mask = c_ST1_MASK;
            2'd2:    w_stage_mask = c_ST2_MASK;
            default: w_stage_mask = c_ST3_MASK;
        endcase
    end

    assign SEQ_VALID = w_stage_mask[r_sq];
    assign SUBSEQ    = {r_sb, (w_counter_cycle ? c_NO_SEQ : {r_sq, r_st})};
    assign TPULSE    = r_tp;
    assign EOC       = w_eoc;
    assign CNT_ACK   = r_cnt_ack;

endmodule
`default_nettype wire

// File: doc/ng_subseq_gen.md
# ng_subseq_gen

Sub-sequence generator: the producer side of the 8-bit `SUBSEQ` word that the sub-sequence decoder turns into the one-hot `NSUBSQ`, `PINC` and `MINC` lines. It runs the 12-pulse instruction-cycle timer and holds the sequence register `SQ` and the stage register `ST`. It arbitrates between instruction cycles and inserted counter-increment cycles and encodes the result as `SUBSEQ = {SB_02, SB_01, SQ[3:0], STB_1, STB_0}`.

## Interface
- No parameters. Widths are fixed by the `SUBSEQ` format.
- `CLK2` in 1: system clock; all state changes on the rising edge.
- `NPURST` in 1: asynchronous, active-low reset.
- `RUN` in 1: the timer advances only when this is 1; all state holds when it is 0.
- `NEWSQ` in 1: sampled at the boundary; loads a new instruction sequence.
- `SQ_IN` in 4: sequence code loaded by `NEWSQ`.
- `STG_ADV` in 1: sampled at the boundary; loads the next stage.
- `STG_NXT` in 2: stage value loaded by `STG_ADV`.
- `CNT_REQ` in 1: counter-increment request, level signal; held until `CNT_ACK`.
- `CNT_DIR` in 1: 0 = plus increment (PINC), 1 = minus increment (MINC); stable while `CNT_REQ` is high.
- `CNT_ACK` out 1: one-cycle grant pulse.
- `SUBSEQ` out 8: encoded sub-sequence word.
- `TPULSE` out 4: current time pulse; 0..11 represents T1..T12.
- `EOC` out 1: end of cycle, `RUN & (TPULSE==11)`, combinational.
- `SEQ_VALID` out 1: the stored `{SQ,ST}` is a decodable code (combinational).

## Operation
- **Timer.** `TP` counts 0..11 and wraps to 0 when `RUN=1`.
- **Boundary.** The boundary is the clock edge taken while `EOC=1`. All sequence updates and arbitration happen only there.
- **Sequence update.** At the boundary:
  - `NEWSQ=1`: `SQ<=SQ_IN`, `ST<=0`. `NEWSQ` has priority over `STG_ADV`.
  - Else `STG_ADV=1`: `ST<=STG_NXT`, `SQ` held.
  - Else both registers hold.
- **Cycle-type register `SB`.**
  - 00 = instruction cycle.
  - 01 = plus-counter cycle.
  - 10 = minus-counter cycle.
  - 11 is never produced.
- **Arbitration.** At the boundary:
  - If the current cycle is an instruction cycle and `CNT_REQ=1`, then `SB<={CNT_DIR,!CNT_DIR}`.
  - Otherwise `SB<=00`.
  - At most one counter cycle is inserted between instruction cycles, so instructions cannot starve.
- **Counter-cycle side effects.** The sequence update at that boundary is still applied to `SQ`/`ST`. It takes effect in the instruction cycle that follows the counter cycle.
- **Acknowledge.** `CNT_ACK` is registered. It is high for exactly the first clock of a granted counter cycle (`TP==0`, `SB!=00`). The requester drops `CNT_REQ` before that cycle's boundary. A request still high at the counter-cycle boundary is not granted; it is reconsidered at the next instruction boundary.
- **Output encoding.**
  - `SUBSEQ[7:6] = {SB[1],SB[0]}`, i.e. `SB_02`, `SB_01`.
  - Instruction cycle: `SUBSEQ[5:0] = {SQ,ST}`.
  - Counter cycle: `SUBSEQ[5:0]` is forced to 6'b111111, which decodes to no sequence.
- **`SEQ_VALID` legal set.** `SEQ_VALID=1` only for these `{SQ,ST}` values (SQ in octal):
  - stage 0: SQ 0, 1, 2, 3, 11, 12, 13, 14, 15, 16, 17
  - stage 1: SQ 0, 1, 2, 11, 12
  - stage 2: SQ 0, 3, 12, 13
  - stage 3: none
- **Illegal stage.** `STG_NXT=3` is loaded as given and `SEQ_VALID` goes to 0. There is no trap; the downstream decoder outputs all-ones.

## Timing
- **Reset values.** `TP=0`, `SQ=0`, `ST=0`, `SB=00`, `CNT_ACK=0`. This gives `SUBSEQ=8'h00` (TC0), `TPULSE=0`, `EOC=0`, `SEQ_VALID=1`.
- **Reset mid-cycle.** Reset asserted during any cycle, including a counter cycle, aborts it immediately. No `CNT_ACK` is issued after release until a new grant.
- **Update latency.** A boundary input appears on `SUBSEQ` one clock after the boundary edge, at `TPULSE=0`. It is stable for 12 running clocks.
- **`RUN` low.** `TP`, `SQ`, `ST`, `SB` and `SUBSEQ` freeze, and `EOC=0`. If `CNT_ACK` is already high, it still deasserts on the next edge.
- **Simultaneous events.**
  - `NEWSQ` + `STG_ADV` + `CNT_REQ` at one boundary: all three take effect. The counter cycle runs first, then the new `SQ` with stage 0.
- **Sampling window.** Inputs are ignored at non-boundary edges.

## Test plan
- **Reset.** Release `NPURST` with `RUN=1`, no inputs → `SUBSEQ=8'h00` for 12 clocks; `TPULSE` steps 0..11 and wraps; `EOC` high only at 11.
- **New sequence.** `NEWSQ=1`, `SQ_IN=4'b1001` at the boundary → next clock `SUBSEQ=8'b00_1001_00`. Then `STG_ADV=1`, `STG_NXT=1` → `8'b00_1001_01`, `SEQ_VALID=1`.
- **Plus-counter insertion.** `CNT_REQ=1`, `CNT_DIR=0` during an instruction cycle → `SUBSEQ=8'b01_111111` for 12 clocks; `CNT_ACK` high only at `TPULSE=0`. A `NEWSQ` (`SQ_IN=4'b1110`) given at the same boundary appears afterwards as `8'b00_1110_00`.
- **No back-to-back counter cycles.** `CNT_REQ` held high through two boundaries with `CNT_DIR=1` → cycle order minus-counter (`8'b10_111111`), instruction, minus-counter; exactly two `CNT_ACK` pulses.
- **Freeze.** `RUN=0` for 5 clocks at `TPULSE=6` → all outputs frozen. `NEWSQ` pulsed during the freeze is ignored.
- **Illegal stage and mid-cycle reset.** Load `SQ=4'b0011`, `ST=3` → `SEQ_VALID=0`. Then assert `NPURST=0` mid counter cycle → all reset values immediately, no `CNT_ACK`.
